// File: rtl/fire_control.sv
// fire_control: turns the pilot's level trigger into rate-limited single-cycle
// fire strobes for the ammo counter, with single-shot and burst modes, arming
// on attack mode, dry-fire reporting on an empty magazine and a shot total.
module fire_control #(
  parameter int AMMO_W    = 9,
  parameter int COOLDOWN  = 3,
  parameter int BURST_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_selector,
  input  logic              trigger,
  input  logic              burst_mode,
  input  logic [AMMO_W-1:0] ammo,
  output logic              fire,
  output logic              dry_fire,
  output logic              busy,
  output logic [7:0]        shots
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  // Counter reload values; both parameters are limited to 1..15 so 4 bits suffice.
  localparam logic [3:0] CD_LOAD    = 4'(COOLDOWN - 1);
  localparam logic [3:0] BURST_LOAD = 4'(BURST_LEN - 1);

  state_t     state_r;
  logic       trig_q_r;
  logic [3:0] burst_left_r;
  logic [3:0] cd_cnt_r;

  logic armed_s;
  logic press_s;
  logic ammo_ok_s;

  // Decode arming, rising-edge press detection and the ammo-present flag.
  always_comb begin
    armed_s   = (mode_selector == 4'b0010);
    press_s   = trigger & ~trig_q_r;
    ammo_ok_s = (ammo != {AMMO_W{1'b0}});
  end

  // Shot sequencer: all outputs are registered and asserted on the edge that
  // enters the state they describe, so fire/busy rise on the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      trig_q_r     <= 1'b0;
      burst_left_r <= 4'd0;
      cd_cnt_r     <= 4'd0;
      fire         <= 1'b0;
      dry_fire     <= 1'b0;
      busy         <= 1'b0;
      shots        <= 8'd0;
    end else begin
      trig_q_r <= trigger;
      fire     <= 1'b0;
      dry_fire <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (press_s && armed_s && ammo_ok_s) begin
            state_r      <= ST_FIRE;
            fire         <= 1'b1;
            busy         <= 1'b1;
            shots        <= shots + 8'd1;
            burst_left_r <= burst_mode ? BURST_LOAD : 4'd0;
          end else if (press_s && armed_s) begin
            // Armed but empty magazine: report it, never fire.
            dry_fire <= 1'b1;
            busy     <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_FIRE: begin
          state_r  <= ST_COOL;
          cd_cnt_r <= CD_LOAD;
          busy     <= 1'b1;
        end
        ST_COOL: begin
          if (cd_cnt_r == 4'd0) begin
            // Decision point: the counter has already consumed the last shot.
            if ((burst_left_r != 4'd0) && armed_s && ammo_ok_s) begin
              state_r      <= ST_FIRE;
              fire         <= 1'b1;
              busy         <= 1'b1;
              shots        <= shots + 8'd1;
              burst_left_r <= burst_left_r - 4'd1;
            end else begin
              // Burst finished or aborted silently (no dry_fire on abort).
              state_r      <= ST_IDLE;
              busy         <= 1'b0;
              burst_left_r <= 4'd0;
            end
          end else begin
            cd_cnt_r <= cd_cnt_r - 4'd1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          burst_left_r <= 4'd0;
          cd_cnt_r     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire_control.sv
// Self-checking bench for fire_control: a timeline-based reference model
// (shot times, pending burst shots, end-of-busy time) checked every cycle,
// a table of single-press scenarios, hand-written corner sequences and a
// randomized soak.
module tb_fire_control;

  localparam int AMMO_W    = 9;
  localparam int COOLDOWN  = 3;
  localparam int BURST_LEN = 3;

  logic              clk;
  logic              rst;
  logic [3:0]        mode_selector;
  logic              trigger;
  logic              burst_mode;
  logic [AMMO_W-1:0] ammo;
  logic              fire;
  logic              dry_fire;
  logic              busy;
  logic [7:0]        shots;

  fire_control #(
    .AMMO_W(AMMO_W), .COOLDOWN(COOLDOWN), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst), .mode_selector(mode_selector), .trigger(trigger),
    .burst_mode(burst_mode), .ammo(ammo), .fire(fire), .dry_fire(dry_fire),
    .busy(busy), .shots(shots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as a timeline.
  int   t_now = 0;        // edge index
  int   last_end = -1;    // edge at which the block is back in IDLE
  int   pending = 0;      // burst shots still owed
  logic prev_trig = 1'b0;
  int   m_shots = 0;
  logic exp_fire = 1'b0;
  logic exp_dry = 1'b0;
  logic exp_busy = 1'b0;

  // Environment: ammo counter model.
  logic cnt_en = 1'b0;
  logic dec_pending = 1'b0;
  int   fire_seen = 0;
  int   dry_seen = 0;

  typedef struct {
    logic [3:0] mode;
    logic       burst;
    int         start_ammo;
    int         exp_fires;
    int         exp_dry;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    last_end  = t_now - 1;
    pending   = 0;
    prev_trig = 1'b0;
    m_shots   = 0;
    exp_fire  = 1'b0;
    exp_dry   = 1'b0;
    exp_busy  = 1'b0;
    dec_pending = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs the DUT sampled.
  task automatic model_edge();
    logic press, armed, has;
    press = trigger && !prev_trig;
    prev_trig = trigger;
    armed = (mode_selector == 4'b0010);
    has   = (ammo != 0);
    exp_fire = 1'b0;
    exp_dry  = 1'b0;
    if (t_now == last_end && pending > 0) begin
      if (armed && has) begin
        exp_fire = 1'b1;
        pending--;
        last_end = t_now + COOLDOWN + 1;
      end else begin
        pending = 0;
      end
    end else if (t_now > last_end && press) begin
      if (armed && has) begin
        exp_fire = 1'b1;
        pending  = burst_mode ? BURST_LEN - 1 : 0;
        last_end = t_now + COOLDOWN + 1;
      end else if (armed) begin
        exp_dry = 1'b1;
      end
    end
    if (exp_fire) m_shots = (m_shots + 1) % 256;
    exp_busy = (t_now < last_end);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    t_now++;
    #1;
    if (cnt_en && dec_pending && ammo != 0) ammo = ammo - 1'b1;
    dec_pending = exp_fire;
    if (fire) fire_seen++;
    if (dry_fire) dry_seen++;
    check("fire", int'(fire), int'(exp_fire));
    check("dry_fire", int'(dry_fire), int'(exp_dry));
    check("busy", int'(busy), int'(exp_busy));
    check("shots", int'(shots), m_shots);
  endtask

  task automatic press_once();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode_selector = 4'b0010; trigger = 1'b0;
    burst_mode = 1'b0; ammo = 9'd500;
    #1;
    check("reset_fire", int'(fire), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_shots", int'(shots), 0);
    check("reset_dry", int'(dry_fire), 0);
    model_reset();
    step(); step();
    #2 rst = 1'b0;
    repeat (3) step();

    // Table of single-press scenarios (bench counter enabled).
    vecs[0] = '{4'b0010, 1'b0, 500, 1, 0};
    vecs[1] = '{4'b0010, 1'b1, 500, 3, 0};
    vecs[2] = '{4'b0010, 1'b1, 2,   2, 0};
    vecs[3] = '{4'b0010, 1'b1, 0,   0, 1};
    vecs[4] = '{4'b0100, 1'b1, 500, 0, 0};
    vecs[5] = '{4'b0011, 1'b0, 500, 0, 0};
    vecs[6] = '{4'b0000, 1'b1, 500, 0, 0};
    vecs[7] = '{4'b0010, 1'b1, 1,   1, 0};
    vecs[8] = '{4'b0010, 1'b0, 0,   0, 1};
    cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mode_selector = vecs[i].mode;
      burst_mode    = vecs[i].burst;
      ammo          = 9'(vecs[i].start_ammo);
      fire_seen = 0; dry_seen = 0;
      press_once();
      repeat (19) step();
      check($sformatf("vec%0d_fires", i), fire_seen, vecs[i].exp_fires);
      check($sformatf("vec%0d_dry", i), dry_seen, vecs[i].exp_dry);
      check($sformatf("vec%0d_ammo", i), int'(ammo),
            vecs[i].start_ammo - vecs[i].exp_fires);
    end

    // Second press while busy is discarded.
    mode_selector = 4'b0010; burst_mode = 1'b0; ammo = 9'd500;
    fire_seen = 0;
    press_once();
    step();
    press_once();
    repeat (10) step();
    check("busy_press_fires", fire_seen, 1);

    // Mode dropped during first cooldown of a burst: one shot only.
    burst_mode = 1'b1; fire_seen = 0;
    press_once();
    step();
    mode_selector = 4'b0001;
    repeat (14) step();
    check("mode_drop_fires", fire_seen, 1);
    mode_selector = 4'b0010;

    // Asynchronous reset during cooldown of shot 2 of a burst.
    ammo = 9'd500; burst_mode = 1'b1;
    press_once();
    repeat (6) step();
    #2 rst = 1'b1;
    #1;
    check("arst_fire", int'(fire), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_shots", int'(shots), 0);
    check("arst_dry", int'(dry_fire), 0);
    model_reset();
    step();
    #2 rst = 1'b0;
    step();
    burst_mode = 1'b0;
    press_once();
    check("post_reset_fire", int'(fire), 1);
    repeat (6) step();

    // Shot counter wrap: 256 single shots with ammo held.
    cnt_en = 1'b0; ammo = 9'd500; burst_mode = 1'b0;
    rst = 1'b1; #1; model_reset(); step(); #2 rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k == 255) check("wrap_pre", int'(shots), 255);
      press_once();
      repeat (5) step();
    end
    check("wrap_post", int'(shots), 0);

    // Randomized soak against the model.
    cnt_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) trigger = ~trigger;
      if ($urandom_range(0, 40) == 0) begin
        case ($urandom_range(0, 4))
          0: ammo = 9'd0;
          1: ammo = 9'd1;
          2: ammo = 9'd2;
          default: ammo = 9'd500;
        endcase
      end
      if ($urandom_range(0, 30) == 0)
        mode_selector = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
      if ($urandom_range(0, 10) == 0) burst_mode = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
